// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// store_monitor : logs MIPS data-memory stores into a FIFO and keeps a
//                 pass/fail verdict on the first store to WATCH_ADDR.
// Revision      : 1.0 - initial release
// ============================================================================
module store_monitor #(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] WATCH_ADDR  = 32'd84,
  parameter logic [31:0] EXPECT_DATA = 32'd7,
  parameter int          TIMEOUT     = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                dataaddr,
  input  logic [31:0]                writedata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_addr,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       misaligned,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timed_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  logic [31:0]   r_addr_mem [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_misaligned;

  logic [1:0]    r_state;
  logic [31:0]   r_cycle;
  logic          r_done;
  logic          r_pass;
  logic          r_fail;
  logic          r_timed_out;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_accept;
  logic w_watch;
  logic w_timeout_hit;

  // Case equality folds an X/Z strobe to "no store".
  assign w_push   = (memwrite === 1'b1);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_watch  = w_push && (dataaddr == WATCH_ADDR);

  generate
    if (TIMEOUT != 0) begin : g_timeout
      localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
      assign w_timeout_hit = (r_cycle == TIMEOUT_LAST);
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_addr_mem[r_wr_ptr] <= dataaddr;
      r_data_mem[r_wr_ptr] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_push && (dataaddr[1:0] != 2'b00)) begin
        r_misaligned <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_cycle     <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_cycle <= r_cycle + 32'd1;
          // A watched store on the timeout edge takes priority.
          if (w_watch) begin
            r_done <= 1'b1;
            if (writedata == EXPECT_DATA) begin
              r_state <= ST_PASS;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end
          end else if (w_timeout_hit) begin
            r_state     <= ST_FAIL;
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_timed_out <= 1'b1;
          end
        end
        ST_PASS: r_state <= ST_PASS;
        ST_FAIL: r_state <= ST_FAIL;
        default: r_state <= ST_FAIL;
      endcase
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_addr   = out_valid ? r_addr_mem[r_rd_ptr] : 32'd0;
  assign out_data   = out_valid ? r_data_mem[r_rd_ptr] : 32'd0;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign misaligned = r_misaligned;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign timed_out  = r_timed_out;

endmodule
`default_nettype wire
